// File: rtl/alu.sv
// 32-bit ALU with a single registered result stage: Res and Zero are both
// captured on the same rising edge, so the flag always describes the current Res.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic [3:0]  ALUCtr,
  output logic [31:0] Res,
  output logic        Zero
);

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_SLTU = 4'h8;
  localparam logic [3:0] OP_SLL  = 4'h9;
  localparam logic [3:0] OP_SRL  = 4'hA;
  localparam logic [3:0] OP_SRA  = 4'hB;
  localparam logic [3:0] OP_NOR  = 4'hC;

  logic [31:0] and_bits;
  logic [31:0] or_bits;
  logic [31:0] xor_bits;
  logic [31:0] nor_bits;
  logic [31:0] res_next;
  logic [31:0] res_reg;
  logic        zero_reg;
  logic [4:0]  shamt;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi = gi + 1) begin : g_bitwise
      assign and_bits[gi] = In1[gi] & In2[gi];
      assign or_bits[gi]  = In1[gi] | In2[gi];
      assign xor_bits[gi] = In1[gi] ^ In2[gi];
      assign nor_bits[gi] = ~(In1[gi] | In2[gi]);
    end
  endgenerate

  // Only the low five bits of In1 select the shift distance.
  assign shamt = In1[4:0];

  always_comb begin
    res_next = 32'h0;
    case (ALUCtr)
      OP_AND:  res_next = and_bits;
      OP_OR:   res_next = or_bits;
      OP_ADD:  res_next = In1 + In2;
      OP_XOR:  res_next = xor_bits;
      OP_SUB:  res_next = In1 - In2;
      // Direct signed compare rather than the subtract sign bit, so overflow cannot corrupt it.
      OP_SLT:  res_next = {31'h0, ($signed(In1) < $signed(In2))};
      OP_SLTU: res_next = {31'h0, (In1 < In2)};
      OP_SLL:  res_next = In2 << shamt;
      OP_SRL:  res_next = In2 >> shamt;
      OP_SRA:  res_next = $unsigned($signed(In2) >>> shamt);
      OP_NOR:  res_next = nor_bits;
      default: res_next = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_reg  <= 32'h0;
      zero_reg <= 1'b1;
    end else begin
      res_reg  <= res_next;
      zero_reg <= (res_next == 32'h0);
    end
  end

  assign Res  = res_reg;
  assign Zero = zero_reg;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the alu: each step drives inputs on the falling
// edge and checks Res/Zero on the falling edge after the next rising edge.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] In1;
  logic [31:0] In2;
  logic [3:0]  ALUCtr;
  logic [31:0] Res;
  logic        Zero;

  int checks;
  int passed;

  alu dut (
    .clk    (clk),
    .reset  (reset),
    .In1    (In1),
    .In2    (In2),
    .ALUCtr (ALUCtr),
    .Res    (Res),
    .Zero   (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op);
    reset  = rst;
    In1    = a;
    In2    = b;
    ALUCtr = op;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] exp_res, input logic exp_zero);
    checks++;
    assert (Res === exp_res && Zero === exp_zero) passed++;
    else $error("FAIL %s: got Res=%h Zero=%b, expected Res=%h Zero=%b",
                tag, Res, Zero, exp_res, exp_zero);
    $display("%-14s In1=%h In2=%h ALUCtr=%h rst=%b -> Res=%h Zero=%b",
             tag, In1, In2, ALUCtr, reset, Res, Zero);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b1;
    In1    = 32'h0;
    In2    = 32'h0;
    ALUCtr = 4'h0;
    @(negedge clk);

    // Reset state, with operands that would otherwise give a non-zero result.
    step(1'b1, 32'hDEADBEEF, 32'h12345678, 4'h1);
    check("reset_state", 32'h0, 1'b1);

    // Basic ops, one per cycle.
    step(1'b0, 32'hFFFF0000, 32'h00FFFF00, 4'h2); check("add",      32'h00FEFF00, 1'b0);
    step(1'b0, 32'hFFFF0000, 32'h00FFFF00, 4'h6); check("sub",      32'hFEFF0100, 1'b0);
    step(1'b0, 32'hFFFF0000, 32'h00FFFF00, 4'h0); check("and",      32'h00FF0000, 1'b0);
    step(1'b0, 32'hFFFF0000, 32'h00FFFF00, 4'h1); check("or",       32'hFFFFFF00, 1'b0);
    step(1'b0, 32'hFFFF0000, 32'h00FFFF00, 4'h7); check("slt",      32'h00000001, 1'b0);
    step(1'b0, 32'hFFFF0000, 32'h00FFFF00, 4'h8); check("sltu",     32'h00000000, 1'b1);
    step(1'b0, 32'hFFFF0000, 32'h00FFFF00, 4'h3); check("xor",      32'hFF00FF00, 1'b0);

    // Signed compare across overflow: 0x80000000 - 1 overflows but is still less.
    step(1'b0, 32'h80000000, 32'h00000001, 4'h7); check("slt_ovf",  32'h00000001, 1'b0);
    step(1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 4'h7); check("slt_ovf2", 32'h00000000, 1'b1);
    step(1'b0, 32'h00000001, 32'h80000000, 4'h8); check("sltu_lt",  32'h00000001, 1'b0);

    // Zero flag and wrap-around.
    step(1'b0, 32'h12345678, 32'h12345678, 4'h6); check("sub_zero", 32'h00000000, 1'b1);
    step(1'b0, 32'hFFFFFFFF, 32'h00000001, 4'h2); check("add_wrap", 32'h00000000, 1'b1);

    // Shifts.
    step(1'b0, 32'h00000004, 32'h80000010, 4'h9); check("sll",      32'h00000100, 1'b0);
    step(1'b0, 32'h00000004, 32'h80000010, 4'hA); check("srl",      32'h08000001, 1'b0);
    step(1'b0, 32'h00000004, 32'h80000010, 4'hB); check("sra",      32'hF8000001, 1'b0);
    step(1'b0, 32'hFFFFFFE0, 32'h80000010, 4'h9); check("sll_zero", 32'h80000010, 1'b0);
    step(1'b0, 32'hFFFFFFE0, 32'h80000010, 4'hB); check("sra_zero", 32'h80000010, 1'b0);
    step(1'b0, 32'h0000001F, 32'h80000000, 4'hA); check("srl_31",   32'h00000001, 1'b0);

    // Undefined codes and NOR.
    step(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h5); check("undef_5",  32'h00000000, 1'b1);
    step(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF); check("undef_f",  32'h00000000, 1'b1);
    step(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h4); check("undef_4",  32'h00000000, 1'b1);
    step(1'b0, 32'h00000000, 32'h00000000, 4'hC); check("nor",      32'hFFFFFFFF, 1'b0);

    // Inputs changing between edges must not reach the outputs early.
    step(1'b0, 32'h0F0F0000, 32'h000000F0, 4'h1); check("or_hold",  32'h0F0F00F0, 1'b0);
    In1    = 32'h00000005;
    In2    = 32'h00000005;
    ALUCtr = 4'h6;
    #2;
    check("between_edges", 32'h0F0F00F0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("after_edge", 32'h00000000, 1'b1);

    // Reset pulse overrides a pending OR, then the next edge computes normally.
    step(1'b0, 32'h0000F000, 32'h0000000F, 4'h1); check("pre_reset", 32'h0000F00F, 1'b0);
    step(1'b1, 32'h0000F000, 32'h0000000F, 4'h1); check("reset_pri", 32'h00000000, 1'b1);
    step(1'b0, 32'h0000F000, 32'h0000000F, 4'h1); check("post_reset", 32'h0000F00F, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
